// File: rtl/water_level_tracker.sv
// Water-tank level tracker: saturating up/down level counter paced by per-mode
// clock-enable prescalers, with band encoding and full/empty/limit reporting.
`timescale 1ns/1ps
module water_level_tracker #(
    parameter int LEVEL_WIDTH    = 3,
    parameter int MAX_LEVEL      = 7,
    parameter int BANDS          = 4,
    parameter int BAND_WIDTH     = 2,
    parameter int DIV_FILL       = 4,
    parameter int DIV_DRAIN_SLOW = 4,
    parameter int DIV_DRAIN_MED  = 3,
    parameter int DIV_DRAIN_FAST = 2,
    parameter int RESET_LEVEL    = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             state,
    input  logic                   load,
    input  logic [LEVEL_WIDTH-1:0] load_value,
    output logic [LEVEL_WIDTH-1:0] count,
    output logic [BAND_WIDTH-1:0]  water_box,
    output logic                   direction,
    output logic                   step,
    output logic                   full,
    output logic                   empty,
    output logic                   limit_hit
);

    localparam int DIV_MAX_A = (DIV_FILL > DIV_DRAIN_SLOW) ? DIV_FILL : DIV_DRAIN_SLOW;
    localparam int DIV_MAX_B = (DIV_DRAIN_MED > DIV_DRAIN_FAST) ? DIV_DRAIN_MED : DIV_DRAIN_FAST;
    localparam int DIV_MAX   = (DIV_MAX_A > DIV_MAX_B) ? DIV_MAX_A : DIV_MAX_B;
    localparam int PRE_WIDTH = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [LEVEL_WIDTH-1:0] MAX_LVL = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [LEVEL_WIDTH-1:0] RST_LVL = LEVEL_WIDTH'(RESET_LEVEL);

    function automatic logic [BAND_WIDTH-1:0] band_of(input logic [LEVEL_WIDTH-1:0] lvl);
        logic [31:0] prod;
        prod = 32'(lvl) * 32'(BANDS);
        return BAND_WIDTH'(prod / 32'(MAX_LEVEL + 1));
    endfunction

    // Terminal prescaler value per mode, indexed by the state encoding.
    logic [PRE_WIDTH-1:0] div_table [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_div
        localparam int DIV_SEL = (gi == 0) ? DIV_FILL :
                                 (gi == 1) ? DIV_DRAIN_SLOW :
                                 (gi == 2) ? DIV_DRAIN_MED : DIV_DRAIN_FAST;
        assign div_table[gi] = PRE_WIDTH'(DIV_SEL - 1);
    end

    logic [PRE_WIDTH-1:0]   pre_reg, pre_next;
    logic [1:0]             mode_reg;
    logic [LEVEL_WIDTH-1:0] count_reg, count_next;
    logic [BAND_WIDTH-1:0]  band_reg;
    logic                   dir_reg, step_reg, step_next, limit_reg, limit_next;
    logic                   full_reg, empty_reg;

    logic [PRE_WIDTH-1:0]   div_last;
    logic [LEVEL_WIDTH-1:0] load_level;
    logic                   mode_change, step_due, filling, at_limit;

    // Prescaler: load or a mode change restarts the interval at the new rate.
    always_comb begin
        div_last    = div_table[state];
        mode_change = (state != mode_reg);
        step_due    = 1'b0;
        pre_next    = pre_reg;
        if (load || mode_change) begin
            pre_next = '0;
        end else if (enable) begin
            if (pre_reg == div_last) begin
                pre_next = '0;
                step_due = 1'b1;
            end else begin
                pre_next = pre_reg + 1'b1;
            end
        end
    end

    always_comb begin
        filling    = (state == 2'b00);
        at_limit   = filling ? (count_reg == MAX_LVL) : (count_reg == '0);
        load_level = (load_value > MAX_LVL) ? MAX_LVL : load_value;
        count_next = count_reg;
        step_next  = 1'b0;
        limit_next = 1'b0;
        if (load) begin
            count_next = load_level;
        end else if (step_due) begin
            if (at_limit) begin
                limit_next = 1'b1;
            end else begin
                step_next  = 1'b1;
                count_next = filling ? (count_reg + 1'b1) : (count_reg - 1'b1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_reg   <= '0;
            mode_reg  <= 2'b00;
            count_reg <= RST_LVL;
            band_reg  <= band_of(RST_LVL);
            dir_reg   <= 1'b1;
            step_reg  <= 1'b0;
            limit_reg <= 1'b0;
            full_reg  <= (RESET_LEVEL == MAX_LEVEL);
            empty_reg <= (RESET_LEVEL == 0);
        end else begin
            pre_reg   <= pre_next;
            mode_reg  <= state;
            count_reg <= count_next;
            band_reg  <= band_of(count_next);
            dir_reg   <= filling;
            step_reg  <= step_next;
            limit_reg <= limit_next;
            full_reg  <= (count_next == MAX_LVL);
            empty_reg <= (count_next == '0);
        end
    end

    assign count     = count_reg;
    assign water_box = band_reg;
    assign direction = dir_reg;
    assign step      = step_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign limit_hit = limit_reg;

endmodule

// File: tb/tb_water_level_tracker.sv
// Self-checking bench for water_level_tracker: vector table, hand-written corner
// sequences, and randomized stimulus against a behavioural level model.
`timescale 1ns/1ps
module tb_water_level_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable, load;
    logic [1:0] state;
    logic [2:0] load_value;
    logic [2:0] count;
    logic [1:0] water_box;
    logic       direction, step, full, empty, limit_hit;

    logic       load2;
    logic [3:0] load_value2;
    logic [3:0] count2;
    logic [1:0] water_box2;
    logic       direction2, step2, full2, empty2, limit_hit2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    water_level_tracker dut (
        .clock(clock), .reset(reset), .enable(enable), .state(state),
        .load(load), .load_value(load_value), .count(count),
        .water_box(water_box), .direction(direction), .step(step),
        .full(full), .empty(empty), .limit_hit(limit_hit)
    );

    water_level_tracker #(.LEVEL_WIDTH(4), .MAX_LEVEL(10)) dut_wide (
        .clock(clock), .reset(reset), .enable(1'b0), .state(2'b00),
        .load(load2), .load_value(load_value2), .count(count2),
        .water_box(water_box2), .direction(direction2), .step(step2),
        .full(full2), .empty(empty2), .limit_hit(limit_hit2)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: counts enabled clocks since the last restart of the
    // interval and moves the level when the mode's interval length is reached.
    int m_level, m_elapsed;
    logic [1:0] m_mode;
    bit m_dir, m_step, m_limit;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4;
            2'd1:    return 4;
            2'd2:    return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_level = 0; m_elapsed = 0; m_mode = 2'd0;
        m_dir = 1'b1; m_step = 1'b0; m_limit = 1'b0;
    endtask

    task automatic model_step();
        m_step = 1'b0;
        m_limit = 1'b0;
        if (load) begin
            m_level = (int'(load_value) > 7) ? 7 : int'(load_value);
            m_elapsed = 0;
        end else if (state != m_mode) begin
            m_elapsed = 0;
        end else if (enable) begin
            m_elapsed++;
            if (m_elapsed == div_of(state)) begin
                m_elapsed = 0;
                if (state == 2'd0) begin
                    if (m_level < 7) begin m_level++; m_step = 1'b1; end
                    else m_limit = 1'b1;
                end else begin
                    if (m_level > 0) begin m_level--; m_step = 1'b1; end
                    else m_limit = 1'b1;
                end
            end
        end
        m_mode = state;
        m_dir = (state == 2'd0);
    endtask

    task automatic compare_model(input int idx);
        check("rnd_count", int'(count), m_level);
        check("rnd_water_box", int'(water_box), (m_level * 4) / 8);
        check("rnd_step", int'(step), int'(m_step));
        check("rnd_limit_hit", int'(limit_hit), int'(m_limit));
        check("rnd_full", int'(full), int'(m_level == 7));
        check("rnd_empty", int'(empty), int'(m_level == 0));
        check("rnd_direction", int'(direction), int'(m_dir));
        $display("rnd %0d: en=%0b st=%0d ld=%0b lv=%0d -> count=%0d box=%0d step=%0b lim=%0b",
                 idx, enable, state, load, load_value, count, water_box, step, limit_hit);
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_step();
        #1;
    endtask

    task automatic do_reset();
        #3 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [1:0] st;
        logic       ld;
        logic [2:0] lv;
        int         exp_count;
        logic       exp_step;
        logic       exp_limit;
        int         exp_box;
        logic       exp_dir;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int steps, limits;

        vecs[0]  = '{1'b1, 2'd0, 1'b1, 3'd5, 5, 1'b0, 1'b0, 2, 1'b1};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 3'd0, 5, 1'b0, 1'b0, 2, 1'b1};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 3'd0, 5, 1'b0, 1'b0, 2, 1'b1};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 3'd0, 5, 1'b0, 1'b0, 2, 1'b1};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 3'd0, 6, 1'b1, 1'b0, 3, 1'b1};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 3'd0, 6, 1'b0, 1'b0, 3, 1'b0};
        vecs[6]  = '{1'b1, 2'd3, 1'b0, 3'd0, 6, 1'b0, 1'b0, 3, 1'b0};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 3'd0, 5, 1'b1, 1'b0, 2, 1'b0};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 3'd0, 5, 1'b0, 1'b0, 2, 1'b0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 3'd0, 5, 1'b0, 1'b0, 2, 1'b0};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 3'd0, 5, 1'b0, 1'b0, 2, 1'b0};
        vecs[11] = '{1'b1, 2'd3, 1'b1, 3'd7, 7, 1'b0, 1'b0, 3, 1'b0};
        vecs[12] = '{1'b1, 2'd0, 1'b0, 3'd0, 7, 1'b0, 1'b0, 3, 1'b1};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 3'd0, 7, 1'b0, 1'b0, 3, 1'b1};
        vecs[14] = '{1'b1, 2'd0, 1'b0, 3'd0, 7, 1'b0, 1'b0, 3, 1'b1};
        vecs[15] = '{1'b1, 2'd0, 1'b0, 3'd0, 7, 1'b0, 1'b0, 3, 1'b1};
        vecs[16] = '{1'b1, 2'd0, 1'b0, 3'd0, 7, 1'b0, 1'b1, 3, 1'b1};

        reset = 1'b0; enable = 1'b0; state = 2'd0; load = 1'b0; load_value = 3'd0;
        load2 = 1'b0; load_value2 = 4'd0;
        model_reset();

        // Reset values
        @(posedge clock); #1;
        check("reset_count", int'(count), 0);
        check("reset_water_box", int'(water_box), 0);
        check("reset_direction", int'(direction), 1);
        check("reset_step", int'(step), 0);
        check("reset_limit_hit", int'(limit_hit), 0);
        check("reset_full", int'(full), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_wide_count", int'(count2), 0);
        $display("reset: count=%0d box=%0d dir=%0b full=%0b empty=%0b", count, water_box, direction, full, empty);
        #2 reset = 1'b1;

        // Vector table
        for (int i = 0; i < 17; i++) begin
            enable = vecs[i].en; state = vecs[i].st; load = vecs[i].ld; load_value = vecs[i].lv;
            tick();
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d_step", i), int'(step), int'(vecs[i].exp_step));
            check($sformatf("vec%0d_limit_hit", i), int'(limit_hit), int'(vecs[i].exp_limit));
            check($sformatf("vec%0d_water_box", i), int'(water_box), vecs[i].exp_box);
            check($sformatf("vec%0d_direction", i), int'(direction), int'(vecs[i].exp_dir));
            $display("vec %0d: en=%0b st=%0d ld=%0b lv=%0d -> count=%0d step=%0b lim=%0b box=%0d dir=%0b",
                     i, enable, state, load, load_value, count, step, limit_hit, water_box, direction);
        end
        load = 1'b0;

        // Fill from reset: one step every 4 clocks up to 7
        state = 2'd0; enable = 1'b1;
        do_reset();
        steps = 0;
        for (int k = 1; k <= 28; k++) begin
            tick();
            steps += int'(step);
            if (k % 4 == 0) begin
                check($sformatf("fill%0d_count", k), int'(count), k / 4);
                check($sformatf("fill%0d_step", k), int'(step), 1);
                check($sformatf("fill%0d_water_box", k), int'(water_box), (k / 4) / 2);
            end
        end
        check("fill_steps", steps, 7);
        check("fill_full", int'(full), 1);
        $display("fill: count=%0d steps=%0d full=%0b", count, steps, full);

        steps = 0; limits = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            steps += int'(step);
            limits += int'(limit_hit);
        end
        check("hold_full_count", int'(count), 7);
        check("hold_full_limits", limits, 2);
        check("hold_full_steps", steps, 0);
        $display("hold full: count=%0d limits=%0d steps=%0d", count, limits, steps);

        // Fast drain to empty
        state = 2'd3;
        tick();
        check("drain_switch_count", int'(count), 7);
        check("drain_switch_step", int'(step), 0);
        check("drain_switch_direction", int'(direction), 0);
        steps = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            steps += int'(step);
        end
        check("drain_count", int'(count), 0);
        check("drain_empty", int'(empty), 1);
        check("drain_steps", steps, 7);
        limits = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            limits += int'(limit_hit);
        end
        check("drain_limits", limits, 2);
        check("drain_hold_count", int'(count), 0);
        $display("drain: count=%0d empty=%0b steps=%0d limits=%0d", count, empty, steps, limits);

        // Mode change 01 -> 10 with prescaler at 3
        state = 2'd1; load = 1'b1; load_value = 3'd4;
        tick();
        load = 1'b0;
        repeat (3) tick();
        state = 2'd2;
        tick();
        check("mchg_edge_count", int'(count), 4);
        check("mchg_edge_step", int'(step), 0);
        tick(); tick();
        check("mchg_wait_count", int'(count), 4);
        tick();
        check("mchg_step_count", int'(count), 3);
        check("mchg_step_step", int'(step), 1);
        $display("mode change: count=%0d step=%0b", count, step);

        // Enable freeze mid-prescale
        state = 2'd1; load = 1'b1; load_value = 3'd4;
        tick();
        load = 1'b0;
        tick(); tick();
        enable = 1'b0;
        steps = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            steps += int'(step);
        end
        check("freeze_count", int'(count), 4);
        check("freeze_steps", steps, 0);
        enable = 1'b1;
        tick();
        check("resume1_count", int'(count), 4);
        tick();
        check("resume2_count", int'(count), 3);
        check("resume2_step", int'(step), 1);
        $display("freeze/resume: count=%0d step=%0b", count, step);

        // Wide build load clamping
        load2 = 1'b1; load_value2 = 4'd7;
        tick();
        check("wide_load7_count", int'(count2), 7);
        check("wide_load7_box", int'(water_box2), 2);
        load_value2 = 4'd15;
        tick();
        check("wide_load15_count", int'(count2), 10);
        check("wide_load15_box", int'(water_box2), 3);
        check("wide_load15_full", int'(full2), 1);
        load2 = 1'b0;
        $display("wide: count=%0d box=%0d full=%0b", count2, water_box2, full2);

        // Randomized run against the model, with an asynchronous reset midway
        state = 2'd0; enable = 1'b1; load = 1'b0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) state = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 15) == 0);
            load_value = 3'($urandom_range(0, 7));
            tick();
            compare_model(i);
            if (i == 150) begin
                #3 reset = 1'b0;
                #1;
                check("async_reset_count", int'(count), 0);
                check("async_reset_empty", int'(empty), 1);
                check("async_reset_direction", int'(direction), 1);
                $display("async reset: count=%0d empty=%0b", count, empty);
                model_reset();
                @(posedge clock);
                #2 reset = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/water_level_tracker.md
# water_level_tracker

Parametrised water-tank level tracker: a saturating up/down level counter stepped by per-mode rate prescalers, with level-band encoding and full/empty flags. It succeeds the fixed 0–7 water-box counter. Gated, muxed frequency clocks are replaced by one system clock and internal clock-enable prescalers. It adds configurable depth, band count and per-mode rates, parallel load, saturation instead of wrap, and limit reporting. It sits between the irrigation-state controller (drives `state`) and the display/alarm logic (consumes `water_box`, `full`, `empty`).

## Interface
Parameters:
- `LEVEL_WIDTH`, default 3: width of `count`, `load_value`; must satisfy 2^LEVEL_WIDTH > MAX_LEVEL.
- `MAX_LEVEL`, default 7: top of range; level spans 0..MAX_LEVEL.
- `BANDS`, default 4: number of display bands, ≥2 and ≤ MAX_LEVEL+1.
- `BAND_WIDTH`, default 2: width of `water_box`; 2^BAND_WIDTH ≥ BANDS.
- `DIV_FILL`, default 4: clocks per step in mode 00 (≥1).
- `DIV_DRAIN_SLOW`, default 4: mode 01 (≥1).
- `DIV_DRAIN_MED`, default 3: mode 10 (≥1).
- `DIV_DRAIN_FAST`, default 2: mode 11 (≥1).
- `RESET_LEVEL`, default 0: level after reset, ≤ MAX_LEVEL.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state while 0.
- `enable`  in  1  1 = prescaler runs; 0 = prescaler and level frozen.
- `state`  in  2  mode: 00 fill, 01 drain slow, 10 drain medium, 11 drain fast.
- `load`  in  1  synchronous parallel load request.
- `load_value`  in  LEVEL_WIDTH  level to load; values > MAX_LEVEL clamp to MAX_LEVEL.
- `count`  out  LEVEL_WIDTH  current level (registered).
- `water_box`  out  BAND_WIDTH  band of current level (registered).
- `direction`  out  1  1 = filling (mode 00), 0 = draining (registered).
- `step`  out  1  one-cycle pulse on the cycle `count` changed due to a step.
- `full`  out  1  `count` == MAX_LEVEL.
- `empty`  out  1  `count` == 0.
- `limit_hit`  out  1  one-cycle pulse: a step fell due while saturated.

## Operation
- Mode divisor D(state) selects DIV_*; prescaler counts 0..D−1 while `enable`=1; at D−1 a step is due and prescaler returns to 0.
- Step due, mode 00: `count`+1 if below MAX_LEVEL, else hold and pulse `limit_hit`. Modes 01/10/11: `count`−1 if above 0, else hold and pulse `limit_hit`.
- `step` pulses only when `count` actually changes by a step; never on load.
- Mode change (state ≠ previous registered state): prescaler cleared to 0 that edge, no step that edge; new rate counts from zero.
- `load`=1: `count` ← min(load_value, MAX_LEVEL), prescaler cleared, no step/limit_hit that cycle; load beats step and mode change.
- `enable`=0: prescaler holds value; `load` still honoured.
- `water_box` = floor(count × BANDS / (MAX_LEVEL+1)), computed on next-count and registered with `count`; defaults: 0–1→0, 2–3→1, 4–5→2, 6–7→3.
- `full`, `empty`, `direction` registered, consistent with `count`/`state` same cycle as they update.
- Reset values: `count`=RESET_LEVEL, `water_box`=band(RESET_LEVEL), `direction`=1, `step`=0, `limit_hit`=0, `full`=(RESET_LEVEL==MAX_LEVEL), `empty`=(RESET_LEVEL==0), prescaler 0, stored mode 00.

## Timing
- All outputs change only on rising `clock` or asynchronously on `reset` falling.
- Steady mode, enable held: first step D clocks after mode entry/load/reset release; then every D clocks.
- D=1: step every clock.
- `direction` follows `state` with one-cycle latency.
- `count`, `water_box`, `full`, `empty`, `step` update on the same edge.
- Reset asserted mid-count: immediate return to reset values; first step D clocks after release edge.
- No wrap-around under any input sequence.

## Test plan
- Reset release, state=00, enable=1, defaults: `count` 0→1 after 4 clocks, reaches 7 after 28; `step` 7 pulses; `water_box` 0,0,1,1,2,2,3,3; `full`=1 at 7.
- Held at 7 in mode 00 for 8 more clocks: `count` stays 7, `limit_hit` pulses twice, `step` never.
- From 7, state=11: `count` decrements every 2 clocks to 0, `direction`=0 one cycle after switch, `empty`=1 at 0; then `limit_hit` every 2 clocks.
- Mode change 01→10 with prescaler at 3: no step that edge; next step 3 clocks later.
- `load`=1, load_value=6 simultaneous with a due step: `count`=6, `water_box`=3, no `step`; load_value=7 in LEVEL_WIDTH=4/MAX_LEVEL=10 build loads 7, value 15 loads 10.
- `enable`=0 for 10 clocks mid-prescale then 1: step resumes with remaining count; `reset` low mid-run → `count`=RESET_LEVEL immediately.
